c64_bus_arbiter: RTL and testbench



---
 rtl/c64_bus_pkg.sv | 16 +
 rtl/bus_stall_counter.sv | 35 +++
 rtl/c64_bus_arbiter.sv | 104 ++++++++++
 tb/tb_c64_bus_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/c64_bus_pkg.sv
// rtl/c64_bus_pkg.sv - shared defaults and bus ownership state encoding for the C64 bus arbiter
package c64_bus_pkg;

  localparam int ADDR_W_DEF   = 16;
  localparam int DATA_W_DEF   = 8;
  localparam int BA_DELAY_DEF = 3;
  localparam int CNT_W_DEF    = 3;

  typedef enum logic [1:0] {
    CPU_OWN = 2'd0,
    BA_WAIT = 2'd1,
    VIC_OWN = 2'd2,
    RELEASE = 2'd3
  } bus_state_e;

endpackage

// File: rtl/bus_stall_counter.sv
// rtl/bus_stall_counter.sv - saturating CPU stall cycle counter with synchronous clear
module bus_stall_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Clear wins over increment; the count sticks at all-ones once reached.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/c64_bus_arbiter.sv
// rtl/c64_bus_arbiter.sv - CPU/VIC memory bus arbiter using the BA/AEC handshake
// Optional stall statistics counter enabled by C64_BUS_STATS_EN.
module c64_bus_arbiter
  import c64_bus_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int BA_DELAY = BA_DELAY_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
`ifdef C64_BUS_STATS_EN
  input  logic              stall_clr,
  output logic [15:0]       stall_count,
`endif
  input  logic [ADDR_W-1:0] cpu_ab,
  input  logic [DATA_W-1:0] cpu_do,
  input  logic              cpu_we,
  output logic              cpu_rdy,
  input  logic              vic_req,
  input  logic [ADDR_W-1:0] vic_ab,
  output logic              vic_grant,
  output logic [ADDR_W-1:0] mem_ab,
  output logic [DATA_W-1:0] mem_do,
  output logic              mem_we
);

  bus_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CPU_OWN: begin
        if (vic_req) begin
          state_d = BA_WAIT;
          cnt_d   = CNT_W'(BA_DELAY - 1);
        end
      end
      BA_WAIT: begin
        // An open CPU write holds the window at zero until it finishes.
        if (!vic_req) begin
          state_d = CPU_OWN;
          cnt_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (!cpu_we) begin
          state_d = VIC_OWN;
        end
      end
      VIC_OWN: begin
        if (!vic_req) begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        state_d = CPU_OWN;
      end
      default: begin
        state_d = CPU_OWN;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CPU_OWN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cpu_rdy   = (state_q == CPU_OWN);
  assign vic_grant = (state_q == VIC_OWN);
  assign mem_do    = cpu_do;

  always_comb begin
    mem_ab = cpu_ab;
    mem_we = 1'b0;
    case (state_q)
      CPU_OWN, BA_WAIT: mem_we = cpu_we & ~reset;
      VIC_OWN:          mem_ab = vic_ab;
      default:          mem_we = 1'b0;
    endcase
  end

`ifdef C64_BUS_STATS_EN
  bus_stall_counter #(
    .W(16)
  ) u_stall (
    .clk   (clk),
    .reset (reset),
    .inc   (~cpu_rdy),
    .clr   (stall_clr),
    .count (stall_count)
  );
`endif

endmodule

// File: tb/tb_c64_bus_arbiter.sv
// tb/tb_c64_bus_arbiter.sv - vector table, directed corners and randomized model check for c64_bus_arbiter
module tb_c64_bus_arbiter;

  localparam int BA_DELAY = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_ab, vic_ab, mem_ab;
  logic [7:0]  cpu_do, mem_do;
  logic        cpu_we, cpu_rdy, vic_req, vic_grant, mem_we;
`ifdef C64_BUS_STATS_EN
  logic        stall_clr;
  logic [15:0] stall_count;
`endif

  always #5 clk = ~clk;

  c64_bus_arbiter #(.BA_DELAY(BA_DELAY)) dut (
    .clk         (clk),
    .reset       (reset),
`ifdef C64_BUS_STATS_EN
    .stall_clr   (stall_clr),
    .stall_count (stall_count),
`endif
    .cpu_ab      (cpu_ab),
    .cpu_do      (cpu_do),
    .cpu_we      (cpu_we),
    .cpu_rdy     (cpu_rdy),
    .vic_req     (vic_req),
    .vic_ab      (vic_ab),
    .vic_grant   (vic_grant),
    .mem_ab      (mem_ab),
    .mem_do      (mem_do),
    .mem_we      (mem_we)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: waiting = edges spent since the request was accepted (-1 if none).
  int m_waiting;
  bit m_vic;
  bit m_turn;
  int m_stalls;

  function automatic bit m_rdy();
    return (m_waiting < 0) && !m_vic && !m_turn;
  endfunction

  task automatic model_reset();
    m_waiting = -1;
    m_vic     = 0;
    m_turn    = 0;
    m_stalls  = 0;
  endtask

  task automatic model_edge();
    if (reset) begin
      model_reset();
      return;
    end
`ifdef C64_BUS_STATS_EN
    if (stall_clr) m_stalls = 0;
    else if (!m_rdy() && m_stalls < 65535) m_stalls++;
`endif
    if (m_turn) begin
      m_turn = 0;
    end else if (m_vic) begin
      if (!vic_req) begin
        m_vic  = 0;
        m_turn = 1;
      end
    end else if (m_waiting >= 0) begin
      if (!vic_req) m_waiting = -1;
      else if (m_waiting + 1 >= BA_DELAY && !cpu_we) begin
        m_waiting = -1;
        m_vic     = 1;
      end else if (m_waiting < 100) m_waiting++;
    end else if (vic_req) begin
      m_waiting = 0;
    end
  endtask

  task automatic check_model(input string tag);
    logic bus_cpu;
    bus_cpu = (m_waiting >= 0) || (!m_vic && !m_turn);
    chk({tag, ".rdy"},   32'(cpu_rdy),   32'(m_rdy()));
    chk({tag, ".grant"}, 32'(vic_grant), 32'(m_vic));
    chk({tag, ".ab"},    32'(mem_ab),    32'(m_vic ? vic_ab : cpu_ab));
    chk({tag, ".do"},    32'(mem_do),    32'(cpu_do));
    chk({tag, ".we"},    32'(mem_we),    32'(bus_cpu ? (cpu_we & ~reset) : 1'b0));
`ifdef C64_BUS_STATS_EN
    chk({tag, ".stalls"}, 32'(stall_count), 32'(m_stalls));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  typedef struct {
    logic        req;
    logic        we;
    logic [15:0] cab;
    logic        exp_rdy;
    logic        exp_grant;
    logic [15:0] exp_ab;
    logic        exp_we;
  } vec_t;

  vec_t vt[22];

  initial begin
    vt[0]  = '{1'b1, 1'b0, 16'h1234, 1'b1, 1'b0, 16'h1234, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 16'h1234, 1'b0, 1'b0, 16'h1234, 1'b0};
    vt[2]  = '{1'b1, 1'b0, 16'h1234, 1'b0, 1'b0, 16'h1234, 1'b0};
    vt[3]  = '{1'b1, 1'b0, 16'h1234, 1'b0, 1'b0, 16'h1234, 1'b0};
    vt[4]  = '{1'b1, 1'b1, 16'h1234, 1'b0, 1'b1, 16'h0400, 1'b0};
    vt[5]  = '{1'b0, 1'b0, 16'h1234, 1'b0, 1'b1, 16'h0400, 1'b0};
    vt[6]  = '{1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, 16'h1234, 1'b0};
    vt[7]  = '{1'b0, 1'b1, 16'h1234, 1'b1, 1'b0, 16'h1234, 1'b1};
    vt[8]  = '{1'b0, 1'b0, 16'h1234, 1'b1, 1'b0, 16'h1234, 1'b0};
    vt[9]  = '{1'b1, 1'b1, 16'hD020, 1'b1, 1'b0, 16'hD020, 1'b1};
    vt[10] = '{1'b1, 1'b1, 16'hD020, 1'b0, 1'b0, 16'hD020, 1'b1};
    vt[11] = '{1'b1, 1'b1, 16'hD020, 1'b0, 1'b0, 16'hD020, 1'b1};
    vt[12] = '{1'b1, 1'b1, 16'hD020, 1'b0, 1'b0, 16'hD020, 1'b1};
    vt[13] = '{1'b1, 1'b1, 16'hD020, 1'b0, 1'b0, 16'hD020, 1'b1};
    vt[14] = '{1'b1, 1'b0, 16'hD020, 1'b0, 1'b0, 16'hD020, 1'b0};
    vt[15] = '{1'b1, 1'b0, 16'hD020, 1'b0, 1'b1, 16'h0400, 1'b0};
    vt[16] = '{1'b0, 1'b0, 16'hD020, 1'b0, 1'b1, 16'h0400, 1'b0};
    vt[17] = '{1'b0, 1'b0, 16'hD020, 1'b0, 1'b0, 16'hD020, 1'b0};
    vt[18] = '{1'b1, 1'b0, 16'h1234, 1'b1, 1'b0, 16'h1234, 1'b0};
    vt[19] = '{1'b1, 1'b0, 16'h1234, 1'b0, 1'b0, 16'h1234, 1'b0};
    vt[20] = '{1'b0, 1'b0, 16'h1234, 1'b0, 1'b0, 16'h1234, 1'b0};
    vt[21] = '{1'b0, 1'b0, 16'h1234, 1'b1, 1'b0, 16'h1234, 1'b0};

    reset   = 1'b1;
    cpu_ab  = 16'h1111;
    cpu_do  = 8'h05;
    cpu_we  = 1'b1;
    vic_req = 1'b0;
    vic_ab  = 16'h0400;
`ifdef C64_BUS_STATS_EN
    stall_clr = 1'b0;
`endif
    model_reset();
    #2;
    chk("reset.rdy",   32'(cpu_rdy),   32'd1);
    chk("reset.grant", 32'(vic_grant), 32'd0);
    chk("reset.we_gated", 32'(mem_we), 32'd0);
    chk("reset.ab",    32'(mem_ab),    32'h1111);
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    cpu_we = 1'b0;

    for (int i = 0; i < 22; i++) begin
      vic_req = vt[i].req;
      cpu_we  = vt[i].we;
      cpu_ab  = vt[i].cab;
      #1;
      chk($sformatf("vec%0d.rdy", i),   32'(cpu_rdy),   32'(vt[i].exp_rdy));
      chk($sformatf("vec%0d.grant", i), 32'(vic_grant), 32'(vt[i].exp_grant));
      chk($sformatf("vec%0d.ab", i),    32'(mem_ab),    32'(vt[i].exp_ab));
      chk($sformatf("vec%0d.we", i),    32'(mem_we),    32'(vt[i].exp_we));
      tick();
    end

    // Asynchronous reset while the VIC owns the bus.
    vic_req = 1'b1;
    cpu_we  = 1'b0;
    cpu_ab  = 16'hC000;
    for (int k = 0; k < 20 && !m_vic; k++) tick();
    chk("areset.reached_vic", 32'(vic_grant), 32'd1);
    cpu_we = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("areset.grant", 32'(vic_grant), 32'd0);
    chk("areset.rdy",   32'(cpu_rdy),   32'd1);
    chk("areset.we",    32'(mem_we),    32'd0);
    model_reset();
    tick();
    reset   = 1'b0;
    vic_req = 1'b0;
    cpu_we  = 1'b0;
    #1;
    chk("areset.ab_after", 32'(mem_ab), 32'hC000);
    check_model("post_reset");
    tick();

`ifdef C64_BUS_STATS_EN
    stall_clr = 1'b1;
    tick();
    stall_clr = 1'b0;
    chk("stats.clr0", 32'(stall_count), 32'd0);
    vic_req = 1'b1;
    for (int k = 0; k < 43; k++) begin
      #1;
      check_model("burst");
      tick();
    end
    vic_req = 1'b0;
    tick();
    tick();
    chk("stats.burst44", 32'(stall_count), 32'd44);
    stall_clr = 1'b1;
    tick();
    stall_clr = 1'b0;
    chk("stats.clr_pulse", 32'(stall_count), 32'd0);
    force dut.u_stall.count_q = 16'hFFFF;
    #1;
    release dut.u_stall.count_q;
    m_stalls = 65535;
    vic_req  = 1'b1;
    repeat (6) tick();
    chk("stats.saturate", 32'(stall_count), 32'hFFFF);
    vic_req = 1'b0;
    repeat (3) tick();
    chk("stats.saturate_hold", 32'(stall_count), 32'hFFFF);
`endif

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 7) == 0) vic_req = ~vic_req;
      cpu_we = ($urandom_range(0, 3) == 0);
      cpu_ab = 16'($urandom);
      vic_ab = 16'($urandom);
      cpu_do = 8'($urandom);
`ifdef C64_BUS_STATS_EN
      stall_clr = ($urandom_range(0, 63) == 0);
`endif
      #1;
      check_model("rand");
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
